// File: rtl/pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// pll_phase_ctrl
//   Sequencer for the PLL dynamic phase-shift port. Each accepted request is
//   expanded into a train of PSPULSE strobes with PSSEL/PSDIR held stable
//   (setup time before the first pulse, fixed high time, fixed low gap after
//   each pulse). The block also keeps a wrapping per-output phase count and
//   aborts with an error if PLL lock drops mid-sequence.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
//   req_ready is high only in IDLE with pll_lock high and reset low; requests
//   presented while busy are ignored, never queued.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pll_lock              PLL LOCK status
//   req_valid/req_ready   request handshake
//   req_sel/dir/steps     target output (0..2), direction (1 = advance), count
//   ps_sel/ps_dir         PLL PSSEL/PSDIR, held in IDLE, stable during pulses
//   ps_pulse              PLL PSPULSE
//   busy                  high in every state except IDLE
//   done/err              one-cycle completion pulse; err qualifies failures
//   phase0..2             accumulated step count per output, modulo 2^PHASE_W
//   dbg_state             current FSM state encoding for observation
// ---------------------------------------------------------------------------
module pll_phase_ctrl #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 8,
   parameter int PHASE_W   = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_sel,
   input  logic               req_dir,
   input  logic [5:0]         req_steps,
   output logic [2:0]         ps_sel,
   output logic               ps_dir,
   output logic               ps_pulse,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [PHASE_W-1:0] phase0,
   output logic [PHASE_W-1:0] phase1,
   output logic [PHASE_W-1:0] phase2,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [PHASE_W-1:0] PH_ONE = PHASE_W'(1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [5:0]           r_steps;
   logic [2:0]           r_ps_sel;
   logic                 r_ps_dir;
   logic                 r_ps_pulse;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic [PHASE_W-1:0]   r_phase0;
   logic [PHASE_W-1:0]   r_phase1;
   logic [PHASE_W-1:0]   r_phase2;

   logic w_accept;
   logic w_active;
   logic w_abort;

   assign req_ready = (r_state == S_IDLE) && pll_lock && !reset;
   assign w_accept  = req_valid && req_ready;
   assign w_active  = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_GAP);
   assign w_abort   = w_active && !pll_lock;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_steps    <= '0;
         r_ps_sel   <= '0;
         r_ps_dir   <= 1'b0;
         r_ps_pulse <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_phase0   <= '0;
         r_phase1   <= '0;
         r_phase2   <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_abort) begin
            // Lock loss wins over everything, including a pulse that would
            // have completed this cycle: that step is not counted.
            r_state    <= S_DONE;
            r_ps_pulse <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_ps_sel <= req_sel;
                     r_ps_dir <= req_dir;
                     r_steps  <= req_steps;
                     r_busy   <= 1'b1;
                     if (req_sel > 3'd2) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                     end else if (req_steps == 6'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_SETUP;
                        r_cnt   <= CNT_W'(SETUP_CYC - 1);
                     end
                  end
               end
               S_SETUP: begin
                  if (r_cnt == '0) begin
                     r_state    <= S_PULSE;
                     r_ps_pulse <= 1'b1;
                     r_cnt      <= CNT_W'(PULSE_CYC - 1);
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               S_PULSE: begin
                  if (r_cnt == '0) begin
                     r_state    <= S_GAP;
                     r_ps_pulse <= 1'b0;
                     r_cnt      <= CNT_W'(GAP_CYC - 1);
                     r_steps    <= r_steps - 6'd1;
                     case (r_ps_sel)
                        3'd0:    r_phase0 <= r_ps_dir ? r_phase0 + PH_ONE : r_phase0 - PH_ONE;
                        3'd1:    r_phase1 <= r_ps_dir ? r_phase1 + PH_ONE : r_phase1 - PH_ONE;
                        3'd2:    r_phase2 <= r_ps_dir ? r_phase2 + PH_ONE : r_phase2 - PH_ONE;
                        default: ;
                     endcase
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               S_GAP: begin
                  if (r_cnt == '0) begin
                     if (r_steps != 6'd0) begin
                        r_state    <= S_PULSE;
                        r_ps_pulse <= 1'b1;
                        r_cnt      <= CNT_W'(PULSE_CYC - 1);
                     end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_ps_pulse <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ps_sel    = r_ps_sel;
   assign ps_dir    = r_ps_dir;
   assign ps_pulse  = r_ps_pulse;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign phase0    = r_phase0;
   assign phase1    = r_phase1;
   assign phase2    = r_phase2;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
module tb_pll_phase_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_sel;
   logic       req_dir;
   logic [5:0] req_steps;
   logic [2:0] ps_sel;
   logic       ps_dir;
   logic       ps_pulse;
   logic       busy;
   logic       done;
   logic       err;
   logic [6:0] phase0;
   logic [6:0] phase1;
   logic [6:0] phase2;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pll_phase_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel   (req_sel),
      .req_dir   (req_dir),
      .req_steps (req_steps),
      .ps_sel    (ps_sel),
      .ps_dir    (ps_dir),
      .ps_pulse  (ps_pulse),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .phase0    (phase0),
      .phase1    (phase1),
      .phase2    (phase2),
      .dbg_state (dbg_state)
   );

   typedef struct {
      int sel;
      int dir;
      int steps;
      int drop_cyc;   // cycle in which pll_lock goes low, -1 = never
      int exp_done;   // cycle of the done pulse, counted from accept edge 0
      int exp_err;
      int exp_p0;
      int exp_p1;
      int exp_p2;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulses occupy cycles 3..6, 15..18, ... and stop before the done cycle.
   function automatic bit exp_pulse(input int c, input int done_c);
      return (c >= 3) && (c < done_c) && (((c - 3) % 12) < 4);
   endfunction

   task automatic run_vec(input int idx);
      vec_t v;
      int   done_c, done_n, err_at, pulse_bad, busy_bad, hold_bad;
      int   p0, p1, p2;
      v = vecs[idx];
      done_c = -1; done_n = 0; err_at = -1;
      pulse_bad = 0; busy_bad = 0; hold_bad = 0;
      p0 = -1; p1 = -1; p2 = -1;
      req_sel   = 3'(v.sel);
      req_dir   = 1'(v.dir);
      req_steps = 6'(v.steps);
      req_valid = 1'b1;
      #1;
      chk($sformatf("v%0d req_ready", idx), int'(req_ready), 1);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= v.exp_done + 2; c++) begin
         if (c == v.drop_cyc) pll_lock = 1'b0;
         if (int'(ps_pulse) != int'(exp_pulse(c, v.exp_done))) pulse_bad++;
         if (int'(busy) != int'(c <= v.exp_done)) busy_bad++;
         if (c <= v.exp_done && (int'(ps_sel) != v.sel || int'(ps_dir) != v.dir)) hold_bad++;
         if (done) begin
            done_n++;
            if (done_c < 0) begin
               done_c = c;
               err_at = int'(err);
               p0 = int'(phase0); p1 = int'(phase1); p2 = int'(phase2);
            end
         end
         @(negedge clk);
      end
      pll_lock = 1'b1;
      chk($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
      chk($sformatf("v%0d done_count", idx), done_n, 1);
      chk($sformatf("v%0d err", idx), err_at, v.exp_err);
      chk($sformatf("v%0d pulse_bad_cycles", idx), pulse_bad, 0);
      chk($sformatf("v%0d busy_bad_cycles", idx), busy_bad, 0);
      chk($sformatf("v%0d sel_dir_bad_cycles", idx), hold_bad, 0);
      chk($sformatf("v%0d phase0", idx), p0, v.exp_p0);
      chk($sformatf("v%0d phase1", idx), p1, v.exp_p1);
      chk($sformatf("v%0d phase2", idx), p2, v.exp_p2);
   endtask

   initial begin
      int dn;
      // sel dir steps drop done err p0 p1 p2 (phases accumulate across rows)
      vecs[0] = '{1, 1, 3, -1, 39, 0, 0, 3, 0};
      vecs[1] = '{2, 0, 1, -1, 15, 0, 0, 3, 127};
      vecs[2] = '{0, 1, 0, -1,  1, 0, 0, 3, 127};
      vecs[3] = '{5, 1, 2, -1,  1, 1, 0, 3, 127};
      vecs[4] = '{0, 1, 3, 17, 18, 1, 1, 3, 127};
      vecs[5] = '{1, 1, 1,  2,  3, 1, 1, 3, 127};
      vecs[6] = '{2, 1, 2, -1, 27, 0, 1, 3, 1};
      vecs[7] = '{1, 0, 2, -1, 27, 0, 1, 1, 1};

      // Reset behaviour
      reset = 1'b1; pll_lock = 1'b1; req_valid = 1'b0;
      req_sel = 3'd0; req_dir = 1'b0; req_steps = 6'd0;
      repeat (3) @(negedge clk);
      chk("reset req_ready", int'(req_ready), 0);
      chk("reset outputs", {ps_sel, ps_dir, ps_pulse, busy, done, err}, 0);
      chk("reset phases", {phase0, phase1, phase2}, 0);
      chk("reset state", int'(dbg_state), 0);
      reset = 1'b0;
      #1;
      chk("post-reset req_ready", int'(req_ready), 1);
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i);

      // Lock low blocks acceptance; raising it accepts in the same cycle;
      // requests while busy are ignored.
      pll_lock = 1'b0; req_valid = 1'b1;
      req_sel = 3'd0; req_dir = 1'b0; req_steps = 6'd1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("nolock req_ready", int'(req_ready), 0);
         chk("nolock busy", int'(busy), 0);
         @(negedge clk);
      end
      pll_lock = 1'b1;
      #1;
      chk("lock-raise req_ready", int'(req_ready), 1);
      @(negedge clk);
      req_sel = 3'd2; req_dir = 1'b1; req_steps = 6'd5;
      dn = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 6) req_valid = 1'b0;
         if (c == 2) chk("busy req_ready", int'(req_ready), 0);
         if (c == 15) chk("b2 done at 15", int'(done), 1);
         if (c == 17) chk("b2 idle after done", int'(busy), 0);
         if (done) dn++;
         @(negedge clk);
      end
      chk("b2 done_count", dn, 1);
      chk("b2 phase0", int'(phase0), 0);
      chk("b2 phase2 untouched", int'(phase2), 1);

      // Reset in the middle of a pulse
      req_sel = 3'd1; req_dir = 1'b1; req_steps = 6'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      dn = 0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) begin
            chk("mid pulse high", int'(ps_pulse), 1);
            reset = 1'b1;
         end
         @(negedge clk);
      end
      reset = 1'b0;
      chk("mid-reset state", int'(dbg_state), 0);
      chk("mid-reset ps_pulse", int'(ps_pulse), 0);
      chk("mid-reset busy", int'(busy), 0);
      chk("mid-reset phases", {phase0, phase1, phase2}, 0);
      for (int c = 0; c < 5; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("mid-reset no done", dn, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
